// File: rtl/encoder_homing_sequencer_pkg.sv
// Shared definitions for the encoder homing sequencer: FSM state
// encodings (3-bit, exported on state_out) and motor direction constants.
package homing_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEEK   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ZERO   = 3'd3;
  localparam logic [2:0] ST_MOVE   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam logic DIR_NEG = 1'b0;  // toward the end-stop
  localparam logic DIR_POS = 1'b1;  // away from the end-stop

  // Busy covers the active homing sequence, SEEK through DONE.
  function automatic logic is_busy(input logic [2:0] s);
    return (s >= ST_SEEK) && (s <= ST_DONE);
  endfunction

endpackage

// File: rtl/encoder_homing_sequencer_endstop_sync.sv
// Two-flop synchroniser for a raw asynchronous switch input.
// Reused for the end-stop and any other limit/switch inputs.
module endstop_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; q is safe to use in clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/encoder_homing_sequencer.sv
// Homing controller for one encoder-driven axis: seek the end-stop, settle,
// zero the quadrature decoder, move out to home_offset, report done.
// Optional stall detection is built when HOMING_STALL_DETECT_EN is defined.
module encoder_homing_sequencer
  import homing_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 50000,
  parameter int unsigned STALL_CYCLES  = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  endstop,
  input  logic [DATA_WIDTH-1:0] home_offset,
  input  logic [DATA_WIDTH-1:0] enc_cnt,
  output logic                  enc_rst,
  output logic                  motor_en,
  output logic                  motor_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_out
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned STL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  if (SETTLE_CYCLES < 1 || STALL_CYCLES < 1) begin : g_bad_params
    $error("encoder_homing_sequencer: SETTLE_CYCLES and STALL_CYCLES must be >= 1");
  end

  logic [2:0]            state, nxt;
  logic                  es_sync;
  logic [DATA_WIDTH-1:0] cnt_s1, cnt_s2, cnt_f;
  logic [SET_W-1:0]      settle_tmr;
  logic                  settle_done;
  logic                  cnt_lt;
  logic                  offset_pos;
  logic                  start_acc;
  logic                  stall_hit;

  endstop_sync u_endstop_sync (
    .clk (clk),
    .rst (rst),
    .d   (endstop),
    .q   (es_sync)
  );

  assign state_out   = state;
  assign settle_done = (settle_tmr == SET_W'(SETTLE_CYCLES - 1));
  assign cnt_lt      = $signed(cnt_f) < $signed(home_offset);
  assign offset_pos  = !home_offset[DATA_WIDTH-1] && (home_offset != '0);

  // Multi-bit CDC filter: accept the decoder count only once two consecutive
  // samples agree; ZERO clears the whole pipe so no pre-zero value leaks into MOVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_s1 <= '0;
      cnt_s2 <= '0;
      cnt_f  <= '0;
    end else if (state == ST_ZERO) begin
      cnt_s1 <= '0;
      cnt_s2 <= '0;
      cnt_f  <= '0;
    end else begin
      cnt_s1 <= enc_cnt;
      cnt_s2 <= cnt_s1;
      if (cnt_s1 == cnt_s2) cnt_f <= cnt_s2;
    end
  end

`ifdef HOMING_STALL_DETECT_EN
  logic [DATA_WIDTH-1:0] cnt_prev;
  logic [STL_W-1:0]      stall_tmr;
  logic                  cnt_chg;

  assign cnt_chg   = (cnt_f != cnt_prev);
  assign stall_hit = !cnt_chg && (stall_tmr == STL_W'(STALL_CYCLES - 1));

  // Stall timer: runs only in SEEK/MOVE, restarts on any filtered-count change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_prev  <= '0;
      stall_tmr <= '0;
    end else begin
      cnt_prev <= cnt_f;
      if (((state != ST_SEEK) && (state != ST_MOVE)) || cnt_chg || (nxt != state))
        stall_tmr <= '0;
      else
        stall_tmr <= stall_tmr + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Settle timer: counts cycles spent in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      settle_tmr <= '0;
    else if ((state == ST_SETTLE) && (nxt == ST_SETTLE))
      settle_tmr <= settle_tmr + 1'b1;
    else
      settle_tmr <= '0;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    nxt       = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          nxt       = ST_SEEK;
          start_acc = 1'b1;
        end
      end
      ST_SEEK: begin
        if (es_sync)        nxt = ST_SETTLE;
        else if (stall_hit) nxt = ST_FAULT;
      end
      ST_SETTLE: if (settle_done) nxt = ST_ZERO;
      ST_ZERO:   nxt = ST_MOVE;
      ST_MOVE: begin
        if (es_sync)        nxt = ST_FAULT;
        else if (!cnt_lt)   nxt = ST_DONE;
        else if (stall_hit) nxt = ST_FAULT;
      end
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (abort) begin
      nxt       = ST_IDLE;
      start_acc = 1'b0;
    end
  end

  // State and registered outputs, all decoded from the next state so every
  // output changes on the same edge as the state it belongs to.
  // Entering MOVE from ZERO enables the motor only for a positive offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      enc_rst   <= 1'b0;
      motor_en  <= 1'b0;
      motor_dir <= DIR_NEG;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= nxt;
      enc_rst   <= (nxt == ST_ZERO);
      motor_en  <= (nxt == ST_SEEK) ||
                   ((nxt == ST_MOVE) && ((state == ST_MOVE) || offset_pos));
      motor_dir <= (nxt == ST_MOVE) ? DIR_POS : DIR_NEG;
      busy      <= is_busy(nxt);
      done      <= (nxt == ST_DONE);
      if (start_acc)
        error <= 1'b0;
      else if ((nxt == ST_FAULT) && (state != ST_FAULT))
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder_homing_sequencer.sv
// Self-checking bench for encoder_homing_sequencer. A small axis plant moves
// the encoder count one step every 8 cycles while the motor is enabled and
// zeroes it on enc_rst; outcomes are predicted from the homing rules.
module tb_encoder_homing_sequencer;

  localparam int S_IDLE = 0, S_SEEK = 1, S_SETTLE = 2, S_ZERO = 3;
  localparam int S_MOVE = 4, S_DONE = 5, S_FAULT = 6;

  logic               clk = 1'b0;
  logic               rst, start, abort, endstop;
  logic [31:0]        home_offset;
  logic signed [31:0] enc;
  logic               enc_rst, motor_en, motor_dir, busy, done, error;
  logic [2:0]         state_out;

  int  checks = 0;
  int  errors = 0;
  int  done_seen, rst_seen, mov_mot;
  int  div = 0;
  bit  freeze = 1'b0;

  always #5 clk = ~clk;

  encoder_homing_sequencer #(
    .DATA_WIDTH    (32),
    .SETTLE_CYCLES (10),
    .STALL_CYCLES  (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .endstop     (endstop),
    .home_offset (home_offset),
    .enc_cnt     (enc),
    .enc_rst     (enc_rst),
    .motor_en    (motor_en),
    .motor_dir   (motor_dir),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .state_out   (state_out)
  );

  // Axis plant: decoder reset wins; otherwise one count per 8 cycles of drive.
  always @(posedge clk) begin
    #2;
    if (!freeze) begin
      if (enc_rst) enc = 0;
      else begin
        div++;
        if (motor_en && (div % 8 == 0)) enc = motor_dir ? enc + 1 : enc - 1;
      end
    end
  end

  // Event monitors.
  always @(posedge clk) begin
    #1;
    if (done) done_seen++;
    if (enc_rst) rst_seen++;
    if (state_out == 3'(S_MOVE) && motor_en) mov_mot++;
  end

  typedef struct {
    int off;
    int seek;
    int abrt;
    int exp_done;
    int exp_final;
    bit chk_final;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    done_seen = 0;
    rst_seen  = 0;
    mov_mot   = 0;
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    for (int i = 0; i < lim && state_out != 3'(s); i++) cyc();
    chk(nm, state_out, s);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    for (int i = 0; i < lim && busy; i++) cyc();
    chk(nm, busy, 0);
  endtask

  // Reference outcome: the axis ends at the offset if positive, else stays at zero.
  function automatic int model_final(input int off);
    return (off > 0) ? off : 0;
  endfunction

  task automatic run_homing(input int off, input int seek_len, input int abort_at);
    clr();
    home_offset = off;
    endstop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (seek_len) cyc();
    endstop = 1'b1;
    wait_state(S_SETTLE, 20, "run_reach_settle");
    endstop = 1'b0;
    if (abort_at > 0) begin
      wait_state(S_MOVE, 40, "run_reach_move");
      repeat (abort_at) cyc();
      abort = 1'b1; cyc(); abort = 1'b0;
    end
    wait_idle(2000, "run_finish");
    repeat (4) cyc();
  endtask

  initial begin
    int n, off, sk, ab;
    rst = 1'b1; start = 1'b0; abort = 1'b0; endstop = 1'b0;
    home_offset = '0; enc = 0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_state", state_out, S_IDLE);
    chk("rst_motor_en", motor_en, 0);
    chk("rst_dir", motor_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_enc_rst", enc_rst, 0);

    // Happy path, offset +25
    clr();
    home_offset = 25;
    start = 1'b1; cyc(); start = 1'b0;
    chk("hp_seek", state_out, S_SEEK);
    chk("hp_seek_motor", motor_en, 1);
    chk("hp_seek_dir", motor_dir, 0);
    chk("hp_seek_busy", busy, 1);
    repeat (39) cyc();
    endstop = 1'b1;
    wait_state(S_SETTLE, 10, "hp_to_settle");
    endstop = 1'b0;
    chk("hp_settle_motor", motor_en, 0);
    n = 0;
    while (state_out == 3'(S_SETTLE) && n < 50) begin n++; cyc(); end
    chk("hp_settle_len", n, 10);
    chk("hp_zero", state_out, S_ZERO);
    chk("hp_zero_enc_rst", enc_rst, 1);
    cyc();
    chk("hp_move", state_out, S_MOVE);
    chk("hp_move_dir", motor_dir, 1);
    chk("hp_move_motor", motor_en, 1);
    chk("hp_move_enc_rst", enc_rst, 0);
    for (int i = 0; i < 1000 && !done; i++) cyc();
    chk("hp_done", done, 1);
    chk("hp_done_busy", busy, 1);
    chk("hp_done_count", enc, 25);
    cyc();
    chk("hp_after_busy", busy, 0);
    chk("hp_after_done", done, 0);
    chk("hp_after_state", state_out, S_IDLE);
    chk("hp_rst_pulses", rst_seen, 1);
    chk("hp_done_pulses", done_seen, 1);

    // End-stop already high, offset 0
    endstop = 1'b1;
    repeat (4) cyc();
    clr();
    home_offset = 0;
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (state_out == 3'(S_SEEK) && n < 20) begin n++; cyc(); end
    chk("es_seek_short", (n >= 1 && n <= 3), 1);
    endstop = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin n++; cyc(); end
    chk("es_done", done, 1);
    chk("es_done_within_16", (n <= 16), 1);
    chk("es_no_move_motion", mov_mot, 0);
    chk("es_count", enc, 0);
    wait_idle(10, "es_idle");

    // Abort five cycles into MOVE
    clr();
    home_offset = 25;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    endstop = 1'b1;
    wait_state(S_SETTLE, 10, "ab_to_settle");
    endstop = 1'b0;
    wait_state(S_MOVE, 20, "ab_to_move");
    repeat (5) cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("ab_state", state_out, S_IDLE);
    chk("ab_motor", motor_en, 0);
    chk("ab_error", error, 0);
    repeat (20) cyc();
    chk("ab_no_done", done_seen, 0);

    // End-stop mid-MOVE faults; start+abort priority; start clears error
    home_offset = 40;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    endstop = 1'b1;
    wait_state(S_SETTLE, 10, "mf_to_settle");
    endstop = 1'b0;
    wait_state(S_MOVE, 20, "mf_to_move");
    repeat (3) cyc();
    endstop = 1'b1;
    wait_state(S_FAULT, 10, "mf_fault");
    chk("mf_error", error, 1);
    chk("mf_motor", motor_en, 0);
    chk("mf_busy", busy, 0);
    endstop = 1'b0;
    start = 1'b1; abort = 1'b1; cyc();
    chk("sa_fault_to_idle", state_out, S_IDLE);
    chk("sa_error_kept", error, 1);
    cyc();
    chk("sa_idle_stays", state_out, S_IDLE);
    chk("sa_idle_motor", motor_en, 0);
    start = 1'b0; abort = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("sa_start_clears_err", error, 0);
    chk("sa_start_seek", state_out, S_SEEK);
    abort = 1'b1; cyc(); abort = 1'b0;
    repeat (3) cyc();

    // Count frozen in SEEK
    freeze = 1'b1;
    enc = 7;
    repeat (5) cyc();
    start = 1'b1; cyc(); start = 1'b0;
`ifdef HOMING_STALL_DETECT_EN
    n = 0;
    while (state_out == 3'(S_SEEK) && n < 300) begin n++; cyc(); end
    chk("stall_seek_cycles", n, 100);
    chk("stall_state", state_out, S_FAULT);
    chk("stall_error", error, 1);
    chk("stall_motor", motor_en, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("stall_start_clears", error, 0);
`else
    repeat (150) cyc();
    chk("nostall_still_seek", state_out, S_SEEK);
    chk("nostall_motor", motor_en, 1);
`endif
    abort = 1'b1; cyc(); abort = 1'b0;
    freeze = 1'b0;
    repeat (3) cyc();

    // Table-driven runs
    tbl[0] = '{25, 40, 0, 1, 25, 1'b1};
    tbl[1] = '{ 0, 10, 0, 1,  0, 1'b1};
    tbl[2] = '{-7, 15, 0, 1,  0, 1'b1};
    tbl[3] = '{ 1,  5, 0, 1,  1, 1'b1};
    tbl[4] = '{30, 20, 5, 0,  0, 1'b0};
    tbl[5] = '{12,  3, 0, 1, 12, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_homing(tbl[i].off, tbl[i].seek, tbl[i].abrt);
      chk($sformatf("tbl%0d_done", i), done_seen, tbl[i].exp_done);
      chk($sformatf("tbl%0d_zero_pulse", i), rst_seen, 1);
      chk($sformatf("tbl%0d_error", i), error, 0);
      chk($sformatf("tbl%0d_motor_off", i), motor_en, 0);
      if (tbl[i].chk_final) chk($sformatf("tbl%0d_final", i), enc, tbl[i].exp_final);
    end

    // Randomised runs against the outcome model
    for (int r = 0; r < 8; r++) begin
      off = int'($urandom_range(80)) - 20;
      sk  = int'($urandom_range(30, 2));
      ab  = (off >= 20 && $urandom_range(1) == 1) ? int'($urandom_range(8, 2)) : 0;
      run_homing(off, sk, ab);
      chk($sformatf("rnd%0d_done off=%0d ab=%0d", r, off, ab), done_seen, (ab > 0) ? 0 : 1);
      chk($sformatf("rnd%0d_error", r), error, 0);
      if (ab == 0) chk($sformatf("rnd%0d_final off=%0d", r, off), enc, model_final(off));
    end

    // Reset mid-SEEK
    home_offset = 10;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    chk("rs_in_seek", state_out, S_SEEK);
    #2 rst = 1'b1;
    #1;
    chk("rs_async_motor", motor_en, 0);
    chk("rs_async_busy", busy, 0);
    chk("rs_async_state", state_out, S_IDLE);
    chk("rs_async_dir", motor_dir, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rs_release_state", state_out, S_IDLE);
    chk("rs_release_motor", motor_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
